// File: rtl/nn_accel_pkg.sv
// nn_accel_pkg
//   Constants and the element type shared between the Wishbone-side
//   operand path and the systolic array.
//   WORD_W : width of one register-write word
//   LANES  : byte lanes (operands) carried by one word
//   ELEM_W : width of one signed operand
package nn_accel_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int ELEM_W = 8;

    // One two's-complement operand as consumed by the array.
    typedef logic signed [ELEM_W-1:0] elem_t;

endpackage

// File: rtl/operand_row_packer_sync_fifo.sv
// sync_fifo
//   First-word-fall-through FIFO with level output.
//   Ports:
//     wb_clk_i    : clock
//     wb_rst_i    : asynchronous active-low reset
//     clear_i     : synchronous clear of pointers and level (wins over push/pop)
//     push_i      : write push_data_i (ignored when full)
//     push_data_i : entry to store
//     pop_i       : discard the head entry (ignored when empty)
//     valid_o     : FIFO not empty
//     full_o      : FIFO holds DEPTH entries
//     head_o      : head entry, zero when empty
//     level_o     : entries stored
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign valid_o = !empty;
    assign level_o = count;
    // Head reads as zero when nothing is stored so stale rows never leak out.
    assign head_o  = empty ? '0 : mem[rd_ptr];

    assign do_push = push_i & !full_o & !clear_i;
    assign do_pop  = pop_i  & !empty  & !clear_i;

    // Storage has no reset; only the pointers decide what is visible.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_row_packer.sv
// operand_row_packer
//   Packs 32-bit register-write words (four signed bytes each) into
//   COLUMNS-element rows and buffers them in a FWFT row FIFO for the
//   systolic array's row loader.
//   Ports:
//     wb_clk_i / wb_rst_i : clock, asynchronous active-low reset
//     wr_en_i, wr_data_i, wr_sel_i, wr_ready_o : word input from the slave
//     flush_i     : synchronous clear of packer, FIFO and flags
//     row_valid_o, row_data_o, row_ready_i     : row output stream
//     level_o     : rows stored
//     overflow_o  : sticky, a write was dropped for lack of space
//     sel_err_o   : sticky, a write with partial byte selects was dropped
//
//   Handshakes: the row stream transfers on a cycle where row_valid_o and
//   row_ready_i are both high; row_data_o holds while valid is high and
//   ready is low. The write side cannot stall: wr_ready_o only tells whether
//   a word offered this cycle will be kept, otherwise it is dropped and
//   flagged. wr_ready_o never depends on row_ready_i.
module operand_row_packer
    import nn_accel_pkg::*;
#(
    parameter int COLUMNS = 8,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wr_en_i,
    input  logic [WORD_W-1:0]          wr_data_i,
    input  logic [3:0]                 wr_sel_i,
    output logic                       wr_ready_o,
    input  logic                       flush_i,
    output logic                       row_valid_o,
    output logic [COLUMNS*WIDTH-1:0]   row_data_o,
    input  logic                       row_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic                       sel_err_o
);

    localparam int WPR   = COLUMNS / LANES;
    localparam int ROW_W = COLUMNS * WIDTH;
    localparam int CNT_W = (WPR > 1) ? $clog2(WPR) : 1;

    logic [CNT_W-1:0] word_cnt;
    logic [ROW_W-1:0] part_row;
    logic [ROW_W-1:0] row_next;
    logic             fifo_full;
    logic             sel_ok;
    logic             last_word;
    logic             accept;
    logic             push;

    assign sel_ok    = (wr_sel_i == 4'hF);
    assign last_word = (word_cnt == CNT_W'(WPR - 1));
    // Only the word that completes a row needs FIFO space; a pop in the same
    // cycle does not help because readiness ignores row_ready_i.
    assign wr_ready_o = !last_word | !fifo_full;
    assign accept     = wr_en_i & wr_ready_o & sel_ok & !flush_i;
    assign push       = accept & last_word;

    // Partial row with the current word dropped into its slot; on the final
    // word this is the complete row pushed in the same cycle.
    always_comb begin
        row_next = part_row;
        row_next[int'(word_cnt)*WORD_W +: WORD_W] = wr_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            word_cnt   <= '0;
            part_row   <= '0;
            overflow_o <= 1'b0;
            sel_err_o  <= 1'b0;
        end else if (flush_i) begin
            word_cnt   <= '0;
            part_row   <= '0;
            overflow_o <= 1'b0;
            sel_err_o  <= 1'b0;
        end else begin
            if (accept) begin
                part_row <= row_next;
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
            // A bad select is reported as such, never as an overflow.
            if (wr_en_i && !sel_ok) begin
                sel_err_o <= 1'b1;
            end
            if (wr_en_i && sel_ok && !wr_ready_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (row_next),
        .pop_i       (row_ready_i),
        .valid_o     (row_valid_o),
        .full_o      (fifo_full),
        .head_o      (row_data_o),
        .level_o     (level_o)
    );

endmodule

// File: tb/tb_operand_row_packer.sv
module tb_operand_row_packer;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_sel_i;
    logic        wr_ready_o;
    logic        flush_i;
    logic        row_valid_o;
    logic [63:0] row_data_o;
    logic        row_ready_i;
    logic [2:0]  level_o;
    logic        overflow_o;
    logic        sel_err_o;

    int tests_run;
    int tests_failed;

    logic [63:0] exp_q[$];

    operand_row_packer #(
        .COLUMNS (8),
        .WIDTH   (8),
        .DEPTH   (4)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .wr_sel_i    (wr_sel_i),
        .wr_ready_o  (wr_ready_o),
        .flush_i     (flush_i),
        .row_valid_o (row_valid_o),
        .row_data_o  (row_data_o),
        .row_ready_i (row_ready_i),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .sel_err_o   (sel_err_o)
    );

    // ---------------- clock / reset ----------------
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(row_valid_o), 64'd0);
        check({tag, "_data"},  row_data_o,       64'd0);
        check({tag, "_level"}, 64'(level_o),     64'd0);
        check({tag, "_ovf"},   64'(overflow_o),  64'd0);
        check({tag, "_sel"},   64'(sel_err_o),   64'd0);
        check({tag, "_rdy"},   64'(wr_ready_o),  64'd1);
    endtask

    // ---------------- drivers ----------------
    // Apply one cycle of inputs at a falling edge, let one rising edge pass,
    // then return to idle at the next falling edge.
    task automatic drive(input logic en, input logic [31:0] d, input logic [3:0] sel,
                         input logic rdy, input logic fl);
        wr_en_i     = en;
        wr_data_i   = d;
        wr_sel_i    = sel;
        row_ready_i = rdy;
        flush_i     = fl;
        @(negedge wb_clk_i);
        wr_en_i     = 1'b0;
        wr_sel_i    = 4'hF;
        row_ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] d);
        drive(1'b1, d, 4'hF, 1'b0, 1'b0);
    endtask

    // Pop the head row and score it against the expected queue.
    task automatic pop_check(input string tag);
        logic [63:0] exp_row;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s observed=queue_empty expected=row", tag);
        end else begin
            exp_row = exp_q.pop_front();
            check({tag, "_valid"}, 64'(row_valid_o), 64'd1);
            check({tag, "_data"},  row_data_o,       exp_row);
        end
        drive(1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wb_rst_i     = 1'b0;
        wr_en_i      = 1'b0;
        wr_data_i    = 32'h0;
        wr_sel_i     = 4'hF;
        row_ready_i  = 1'b0;
        flush_i      = 1'b0;

        repeat (2) @(negedge wb_clk_i);
        check_reset_values("reset");
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);

        // Basic two-word row.
        write_word(32'h04030201);
        check("w1_no_row", 64'(row_valid_o), 64'd0);
        write_word(32'h08070605);
        check("row1_valid", 64'(row_valid_o), 64'd1);
        check("row1_data",  row_data_o, 64'h0807060504030201);
        check("row1_level", 64'(level_o), 64'd1);
        exp_q.push_back(64'h0807060504030201);
        pop_check("row1_pop");
        check("row1_empty", 64'(row_valid_o), 64'd0);
        check("row1_lvl0",  64'(level_o), 64'd0);

        // Fill four rows without popping.
        for (int i = 0; i < 4; i++) begin
            write_word(32'hA0A0A000 | 32'(i));
            write_word(32'hB0B0B000 | 32'(i));
            exp_q.push_back({32'hB0B0B000 | 32'(i), 32'hA0A0A000 | 32'(i)});
        end
        check("full_level", 64'(level_o), 64'd4);
        check("full_rdy_w0", 64'(wr_ready_o), 64'd1);
        write_word(32'hC0C0C0C0);               // 9th word, accepted
        check("full_rdy_w1", 64'(wr_ready_o), 64'd0);
        check("full_no_ovf", 64'(overflow_o), 64'd0);
        write_word(32'hDEADBEEF);               // 10th word, dropped
        check("ovf_set",     64'(overflow_o), 64'd1);
        check("ovf_level",   64'(level_o), 64'd4);
        check("ovf_rdy",     64'(wr_ready_o), 64'd0);

        // Final word at full is dropped even with a pop in the same cycle.
        check("pop_drop_head", row_data_o, exp_q[0]);
        drive(1'b1, 32'hC1C1C1C1, 4'hF, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        check("pop_drop_level", 64'(level_o), 64'd3);
        check("pop_drop_rdy",   64'(wr_ready_o), 64'd1);
        write_word(32'hC1C1C1C1);
        exp_q.push_back(64'hC1C1C1C1C0C0C0C0);
        check("refill_level", 64'(level_o), 64'd4);

        // Full, word_cnt=0: pop plus a non-final write.
        check("simul_head", row_data_o, exp_q[0]);
        drive(1'b1, 32'hE0E0E0E0, 4'hF, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        check("simul_level", 64'(level_o), 64'd3);
        check("simul_valid", 64'(row_valid_o), 64'd1);
        write_word(32'hE1E1E1E1);
        exp_q.push_back(64'hE1E1E1E1E0E0E0E0);
        check("simul_full", 64'(level_o), 64'd4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
        check("drain_empty", 64'(row_valid_o), 64'd0);
        check("ovf_sticky",  64'(overflow_o), 64'd1);

        // Flush clears the sticky overflow.
        drive(1'b0, 32'h0, 4'hF, 1'b0, 1'b1);
        check("flush_ovf", 64'(overflow_o), 64'd0);

        // Bad select.
        drive(1'b1, 32'h55555555, 4'h3, 1'b0, 1'b0);
        check("sel_err",     64'(sel_err_o), 64'd1);
        check("sel_no_ovf",  64'(overflow_o), 64'd0);
        check("sel_level",   64'(level_o), 64'd0);
        write_word(32'h44332211);
        check("sel_cnt_kept", 64'(row_valid_o), 64'd0);
        write_word(32'h88776655);
        check("sel_row", row_data_o, 64'h8877665544332211);
        check("sel_sticky", 64'(sel_err_o), 64'd1);

        // Flush together with a write after one word of a new row.
        write_word(32'h99999999);
        drive(1'b1, 32'h77777777, 4'hF, 1'b0, 1'b1);
        check("flush_level", 64'(level_o), 64'd0);
        check("flush_valid", 64'(row_valid_o), 64'd0);
        check("flush_sel",   64'(sel_err_o), 64'd0);
        check("flush_data",  row_data_o, 64'd0);
        write_word(32'h0A0B0C0D);
        write_word(32'h01020304);
        exp_q.push_back(64'h010203040A0B0C0D);
        check("post_flush_lvl", 64'(level_o), 64'd1);
        pop_check("post_flush");

        // Asynchronous reset mid-row with two rows stored.
        write_word(32'h11111111);
        write_word(32'h22222222);
        write_word(32'h33333333);
        write_word(32'h44444444);
        write_word(32'h55555555);
        check("pre_rst_level", 64'(level_o), 64'd2);
        #2;
        wb_rst_i = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        write_word(32'h13121110);
        check("rst_no_partial", 64'(row_valid_o), 64'd0);
        write_word(32'h17161514);
        exp_q.push_back(64'h1716151413121110);
        check("rst_row_level", 64'(level_o), 64'd1);
        pop_check("rst_row");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_row_packer.md
# operand_row_packer

Downstream neighbour of the Wishbone slave. Consumes 32-bit register-write words carrying packed 8-bit signed operands, assembles them into full COLUMNS-element rows, and buffers the rows in a small FIFO. Rows are presented to the systolic array's row loader over a valid/ready stream. The block reports fill level and sticky error flags back to the slave's status registers.

## Interface
Parameters:
- COLUMNS, 8, elements per row; must be a multiple of 4 (WORDS_PER_ROW = COLUMNS/4).
- WIDTH, 8, element width; fixed at 8 (four lanes per 32-bit word).
- DEPTH, 4, row FIFO depth; must be a power of 2, ≥2.

Ports:
- wb_clk_i  in  1  clock; reset wb_rst_i, asynchronous, active-low; clock wb_clk_i.
- wb_rst_i  in  1  asynchronous active-low reset.
- wr_en_i  in  1  one-cycle write strobe from the slave.
- wr_data_i  in  32  packed word; byte lane b = bits 8b+7:8b.
- wr_sel_i  in  4  byte selects; only 4'hF is legal.
- wr_ready_o  out  1  word will be accepted this cycle.
- flush_i  in  1  synchronous clear of packer, FIFO and flags.
- row_valid_o  out  1  head row available.
- row_data_o  out  COLUMNS*WIDTH  head row; element k at bits k*8 +: 8.
- row_ready_i  in  1  consumer takes head row.
- level_o  out  $clog2(DEPTH)+1  rows stored in FIFO.
- overflow_o  out  1  sticky: a write was dropped because wr_ready_o was low.
- sel_err_o  out  1  sticky: a write with wr_sel_i != 4'hF was dropped.

## Operation
- Packer holds word_cnt (0..WORDS_PER_ROW-1) and a partial row register. A word is accepted when wr_en_i & wr_ready_o & wr_sel_i==4'hF & !flush_i.
- An accepted word's lane b is written to element word_cnt*4+b. On a non-final word, word_cnt increments.
- On the final word (word_cnt==WORDS_PER_ROW-1), the complete row (partial register plus current word) is pushed into the FIFO in the same cycle, and word_cnt returns to 0.
- wr_ready_o = (word_cnt != WORDS_PER_ROW-1) | !full. It does not depend on row_ready_i. A write at full on the final word is dropped even if a pop happens in the same cycle.
- The slave cannot stall. Any wr_en_i while wr_ready_o is low is dropped, sets overflow_o, and leaves word_cnt unchanged. A bad select takes priority as the reported error: it sets sel_err_o, does not set overflow_o, and is dropped.
- The FIFO is first-word-fall-through. row_valid_o = !empty. A pop happens on row_valid_o & row_ready_i. Push and pop in the same cycle are allowed at any level, including full with pop plus a non-final write.
- Elements are passed through unchanged as two's-complement bytes; no arithmetic.
- flush_i has priority over everything in its cycle. It clears word_cnt, the FIFO pointers, level, overflow_o and sel_err_o. Writes and pops in that cycle are ignored.

## Timing
- Reset values: row_valid_o=0, row_data_o=0, level_o=0, overflow_o=0, sel_err_o=0, wr_ready_o=1, word_cnt=0.
- Final word accepted at edge N: row_valid_o=1 and level_o incremented after edge N, with 1-cycle latency.
- Pop at edge N: the next row (or row_valid_o=0) is visible after edge N.
- row_data_o is stable while row_valid_o & !row_ready_i.
- Error flags rise the cycle after the offending write and hold until flush or reset.
- Reset mid-row discards the partial row; no partial row is ever emitted.
- Pointers wrap modulo DEPTH. level_o saturates only by construction, since push is blocked at full.

## Structure
- Package nn_accel_pkg: WORD_W=32, LANES=4, ELEM_W=8 constants, and the element typedef shared with the array.
- Sub-module sync_fifo (WIDTH=COLUMNS*8, DEPTH): FWFT, async active-low reset, with level output.
- The packer, error flags and ready logic live in the top module.

## Test plan
- COLUMNS=8, DEPTH=4: write 32'h04030201 then 32'h08070605 → after the second edge, row_valid_o=1 and row_data_o=64'h0807060504030201, level_o=1.
- Fill 4 rows with row_ready_i=0, then write a 9th word → accepted (word_cnt 0→1). The 10th word is dropped, overflow_o=1, wr_ready_o=0, level_o stays 4.
- At full with word_cnt=0, assert row_ready_i and write → word accepted, level_o=3 after pop, row_valid_o stays 1.
- Write with wr_sel_i=4'h3 → sel_err_o=1, overflow_o=0, word_cnt unchanged. A following 2-word row is packed correctly.
- After one word, pulse flush_i together with wr_en_i → level_o=0, flags clear, next row starts at element 0.
- Assert wb_rst_i low mid-row with 2 rows stored → all outputs at reset values immediately. After release, a fresh 2-word row appears intact.
